pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter owner and fetch/execute sequencer for the McCoy core.
- Consumes the next-PC select (1 = PC+1, 0 = ALU target) produced by the branch logic, and the ALU jump target.
- Drives the fetch address, latches the fetched instruction over a valid/ready handshake, and paces the datapath one instruction at a time.
- Sits between the external instruction source (tile IO) and the decode/ALU/branch path.

Parameters:
- PC_W, 6, program counter width; address space 2^PC_W words.
- INSTR_W, 8, instruction width latched per fetch.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset, sampled on rising clk.
- pc_sel  in  1  next-PC select from branch logic: 1 = PC+1, 0 = alu_target.
- alu_target  in  PC_W  jump/branch target from ALU.
- instr_in  in  INSTR_W  instruction data from fetch source.
- instr_valid  in  1  instr_in holds the word for fetch_addr.
- halt  in  1  stall request; freezes sequencing at the next FETCH entry.
- fetch_addr  out  PC_W  address being fetched (= PC).
- fetch_req  out  1  fetch request; high throughout FETCH.
- instr_out  out  INSTR_W  latched instruction for decode.
- exec_en  out  1  one-cycle strobe: datapath executes instr_out; register writes are committed on this cycle only.
- pc  out  PC_W  current program counter.
- link_out  out  PC_W  return address (see Optional Feature).

Behaviour:
- Clock: single clock domain on clk.
- States: FETCH, EXEC, UPDATE, HALTED; encoding 2 bits.
- Reset (synchronous, active-high; dominates every other input):
  - state=FETCH, pc=0, instr_out=0, link_out=0, exec_en=0.
  - fetch_req=1 from the first cycle after reset deasserts.
- FETCH:
  - fetch_req=1, fetch_addr=pc.
  - On a cycle with instr_valid=1: instr_out<=instr_in, go to EXEC.
  - instr_valid=0: remain in FETCH; there is no timeout.
- EXEC:
  - exec_en=1 for exactly one cycle; fetch_req=0.
  - pc_sel and alu_target are sampled at the end of this cycle. Both are combinational outputs of decode, branch and ALU on instr_out.
  - Go to UPDATE.
- UPDATE:
  - pc<=pc_sel ? pc+1 : alu_target.
  - Increment is modulo 2^PC_W: 63 -> 0 at PC_W=6, with no flag.
  - Go to HALTED if halt=1, else FETCH.
- HALTED:
  - fetch_req=0; pc and instr_out are held.
  - Return to FETCH on the first cycle halt=0.
- halt is ignored in FETCH and EXEC. An in-flight instruction always completes before the stall takes effect.
- Minimum instruction period: 3 cycles (FETCH with instr_valid already high, EXEC, UPDATE).
- instr_valid outside FETCH is ignored, and instr_in is not latched.
- Reset asserted mid-EXEC: exec_en=0 on the following cycle and the pending PC update is discarded.
- alu_target equal to the current pc (self-jump) is legal; the same instruction is re-fetched.
- Outputs are registered except fetch_addr (= pc) and fetch_req/exec_en, which decode the state register only. None of them depends on an input combinationally.

Optional Feature:
- Macro: MCCOY_LINK_REG_EN.
- Defined:
  - In UPDATE with pc_sel=0 (jump taken), link_out<=pc+1, modulo 2^PC_W.
  - With pc_sel=1, link_out holds.
  - Reset clears link_out to 0.
- Undefined: link_out is tied to 0 and no register is inferred.

Decomposition:
- Shared package mccoy_pkg holds:
  - PC_W/INSTR_W defaults;
  - the state enum constants S_FETCH=2'd0, S_EXEC=2'd1, S_UPDATE=2'd2, S_HALTED=2'd3;
  - PCSEL_INC=1'b1 and PCSEL_ALU=1'b0, which the branch logic also uses.
- One sub-module is natural: pc_next (combinational next-PC mux plus modulo incrementer), instanced once.
- The FSM stays in pc_sequencer.

Test Plan:
- Reset, then instr_valid held high with pc_sel=1 for 4 instructions:
  - fetch_addr sequence 0,1,2,3;
  - exec_en pulses exactly every 3rd cycle;
  - pc=4 afterwards.
- Fetch stall: instr_valid low for 5 cycles in FETCH at pc=2, then high with instr_in=8'hA5:
  - fetch_req high for all 6 cycles;
  - instr_out=8'hA5;
  - exactly one exec_en.
- Jump: at pc=5 drive pc_sel=0, alu_target=6'd40:
  - next fetch_addr=40;
  - with MCCOY_LINK_REG_EN, link_out=6;
  - without it, link_out=0.
- Wrap-around at pc=63 with pc_sel=1: next pc=0, with no glitch on fetch_req.
- halt asserted during EXEC at pc=10:
  - UPDATE completes (pc=11) and the FSM enters HALTED;
  - fetch_req=0 while halted;
  - after halt drops, FETCH of 11.
- Reset asserted in EXEC at pc=7 with pc_sel=0, alu_target=20:
  - next cycle pc=0 and state FETCH;
  - the jump to 20 is never taken.

Source files
------------

// File: rtl/mccoy_pkg.sv
// Shared McCoy core definitions: datapath width defaults, sequencer state
// encoding and the next-PC select values also used by the branch logic.
package mccoy_pkg;

  localparam int unsigned PC_W_DEF    = 6;
  localparam int unsigned INSTR_W_DEF = 8;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_UPDATE = 2'd2,
    S_HALTED = 2'd3
  } seq_state_t;

  localparam logic PCSEL_INC = 1'b1;
  localparam logic PCSEL_ALU = 1'b0;

endpackage

// File: rtl/pc_sequencer_pc_next.sv
// Next-PC selection: modulo-2^PC_W increment or ALU jump target.
module pc_next
  import mccoy_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEF
) (
  input  logic [PC_W-1:0] pc,
  input  logic            pc_sel,
  input  logic [PC_W-1:0] alu_target,
  output logic [PC_W-1:0] pc_inc,
  output logic [PC_W-1:0] next_pc
);

  always_comb begin
    pc_inc  = pc + PC_W'(1);
    next_pc = (pc_sel == PCSEL_INC) ? pc_inc : alu_target;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch/execute sequencer for the McCoy core.
// Optional link register enabled by defining MCCOY_LINK_REG_EN.
module pc_sequencer
  import mccoy_pkg::*;
#(
  parameter int unsigned PC_W    = PC_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pc_sel,
  input  logic [PC_W-1:0]    alu_target,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic               instr_valid,
  input  logic               halt,
  output logic [PC_W-1:0]    fetch_addr,
  output logic               fetch_req,
  output logic [INSTR_W-1:0] instr_out,
  output logic               exec_en,
  output logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    link_out
);

  seq_state_t      state_q, state_d;
  logic            sel_q;
  logic [PC_W-1:0] tgt_q;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_nxt;

  pc_next #(.PC_W(PC_W)) u_pc_next (
    .pc         (pc),
    .pc_sel     (sel_q),
    .alu_target (tgt_q),
    .pc_inc     (pc_inc),
    .next_pc    (pc_nxt)
  );

  always_comb begin
    state_d   = state_q;
    fetch_req = 1'b0;
    exec_en   = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch_req = 1'b1;
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        exec_en = 1'b1;
        state_d = S_UPDATE;
      end
      S_UPDATE: state_d = halt ? S_HALTED : S_FETCH;
      S_HALTED: if (!halt) state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Branch result is captured at the end of EXEC so UPDATE is immune to
  // decode outputs changing once exec_en has dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      pc        <= '0;
      instr_out <= '0;
      sel_q     <= PCSEL_INC;
      tgt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid) instr_out <= instr_in;
      if (state_q == S_EXEC) begin
        sel_q <= pc_sel;
        tgt_q <= alu_target;
      end
      if (state_q == S_UPDATE) pc <= pc_nxt;
    end
  end

  assign fetch_addr = pc;

`ifdef MCCOY_LINK_REG_EN
  logic [PC_W-1:0] link_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      link_q <= '0;
    end else if (state_q == S_UPDATE && sel_q == PCSEL_ALU) begin
      link_q <= pc_inc;
    end
  end

  assign link_out = link_q;
`else
  logic link_unused;

  assign link_unused = ^pc_inc;
  assign link_out    = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: every executed instruction is popped
// and compared against the address/instruction expected when it was queued.
module tb_pc_sequencer;

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] instr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pc_sel = 1'b1;
  logic [5:0] alu_target = '0;
  logic [7:0] instr_in;
  logic       instr_valid = 1'b0;
  logic       halt = 1'b0;
  logic [5:0] fetch_addr;
  logic       fetch_req;
  logic [7:0] instr_out;
  logic       exec_en;
  logic [5:0] pc;
  logic [5:0] link_out;

  logic [7:0]  mem [64];
  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned n_exec = 0;
  int unsigned cyc = 0;

  pc_sequencer #(.PC_W(6), .INSTR_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pc_sel      (pc_sel),
    .alu_target  (alu_target),
    .instr_in    (instr_in),
    .instr_valid (instr_valid),
    .halt        (halt),
    .fetch_addr  (fetch_addr),
    .fetch_req   (fetch_req),
    .instr_out   (instr_out),
    .exec_en     (exec_en),
    .pc          (pc),
    .link_out    (link_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign instr_in = mem[fetch_addr];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exec_en === 1'b1) begin
      n_exec++;
      if (sb.size() == 0) begin
        check_val("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_val("exec_addr", 32'(fetch_addr), 32'(e.addr));
        check_val("exec_instr", 32'(instr_out), 32'(e.instr));
      end
    end
  end

  task automatic wait_exec(output int unsigned at);
    bit got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (exec_en === 1'b1) got = 1'b1;
    end
    if (!got) check_val("exec_timeout", 32'd0, 32'd1);
    at = cyc;
  endtask

  function automatic exp_t mk(input int unsigned a);
    exp_t e;
    e.addr  = 6'(a);
    e.instr = mem[a];
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned t_prev, t_now, base;
    logic [5:0] exp_link;
    for (int unsigned i = 0; i < 64; i++) mem[i] = 8'(i * 7 + 3);
    mem[2] = 8'hA5;
`ifdef MCCOY_LINK_REG_EN
    exp_link = 6'd6;
`else
    exp_link = 6'd0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check_val("rst_pc", 32'(pc), 32'd0);
    check_val("rst_instr", 32'(instr_out), 32'd0);
    check_val("rst_exec", 32'(exec_en), 32'd0);
    check_val("rst_link", 32'(link_out), 32'd0);
    check_val("rst_freq", 32'(fetch_req), 32'd1);

    // Back-to-back sequential fetches
    reset = 1'b0;
    pc_sel = 1'b1;
    instr_valid = 1'b1;
    for (int unsigned i = 0; i < 4; i++) sb.push_back(mk(i));
    t_prev = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      wait_exec(t_now);
      if (i > 0) check_val("exec_period", t_now - t_prev, 32'd3);
      t_prev = t_now;
    end
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("seq_pc4", 32'(pc), 32'd4);
    check_val("seq_freq", 32'(fetch_req), 32'd1);

    // Jump at pc=5 to 40
    sb.push_back(mk(4));
    instr_valid = 1'b1;
    wait_exec(t_now);
    sb.push_back(mk(5));
    wait_exec(t_now);
    pc_sel = 1'b0;
    alu_target = 6'd40;
    sb.push_back(mk(40));
    @(negedge clk);
    pc_sel = 1'b1;
    @(negedge clk);
    check_val("jump_addr", 32'(fetch_addr), 32'd40);
    check_val("jump_link", 32'(link_out), 32'(exp_link));

    // Fetch stall at pc=2
    wait_exec(t_now);
    pc_sel = 1'b0;
    alu_target = 6'd2;
    sb.push_back(mk(2));
    @(negedge clk);
    pc_sel = 1'b1;
    instr_valid = 1'b0;
    base = n_exec;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check_val("stall_freq", 32'(fetch_req), 32'd1);
      check_val("stall_exec", 32'(exec_en), 32'd0);
      check_val("stall_addr", 32'(fetch_addr), 32'd2);
      if (k == 6) instr_valid = 1'b1;
    end
    wait_exec(t_now);
    check_val("stall_instr", 32'(instr_out), 32'hA5);
    pc_sel = 1'b0;
    alu_target = 6'd63;
    sb.push_back(mk(63));
    @(negedge clk);
    check_val("stall_one_exec", n_exec - base, 32'd1);
    pc_sel = 1'b1;

    // Wrap-around 63 -> 0
    wait_exec(t_now);
    sb.push_back(mk(0));
    @(negedge clk);
    check_val("wrap_upd_freq", 32'(fetch_req), 32'd0);
    check_val("wrap_upd_pc", 32'(pc), 32'd63);
    @(negedge clk);
    check_val("wrap_freq", 32'(fetch_req), 32'd1);
    check_val("wrap_pc", 32'(pc), 32'd0);

    // Halt raised during EXEC at pc=10
    wait_exec(t_now);
    pc_sel = 1'b0;
    alu_target = 6'd10;
    sb.push_back(mk(10));
    @(negedge clk);
    pc_sel = 1'b1;
    wait_exec(t_now);
    halt = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("halt_pc", 32'(pc), 32'd11);
      check_val("halt_freq", 32'(fetch_req), 32'd0);
      check_val("halt_exec", 32'(exec_en), 32'd0);
    end
    halt = 1'b0;
    sb.push_back(mk(11));
    @(negedge clk);
    check_val("resume_addr", 32'(fetch_addr), 32'd11);
    check_val("resume_freq", 32'(fetch_req), 32'd1);

    // Reset during EXEC at pc=7 with a pending jump to 20
    wait_exec(t_now);
    pc_sel = 1'b0;
    alu_target = 6'd7;
    sb.push_back(mk(7));
    @(negedge clk);
    pc_sel = 1'b1;
    wait_exec(t_now);
    pc_sel = 1'b0;
    alu_target = 6'd20;
    reset = 1'b1;
    @(negedge clk);
    check_val("rexec_exec", 32'(exec_en), 32'd0);
    check_val("rexec_pc", 32'(pc), 32'd0);
    check_val("rexec_freq", 32'(fetch_req), 32'd1);
    check_val("rexec_link", 32'(link_out), 32'd0);
    instr_valid = 1'b0;
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_val("rexec_nojump", 32'(pc), 32'd0);
    end

    check_val("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
